// File: rtl/ahb_periph_responder_pkg.sv
// Shared types for the AHB-Lite peripheral responder.
// Transfer/size encodings, FSM states and the byte-lane strobe helper.
package ahb_periph_responder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2,
        ST_LAST
    } resp_state_e;

    function automatic logic [3:0] byte_lanes(
        input logic [1:0] addr,
        input logic [2:0] hsize
    );
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (hsize)
            HSIZE_BYTE: lanes = 4'b0001 << addr;
            HSIZE_HALF: lanes = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lanes = 4'b1111;
            default:    lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_periph_responder_mem.sv
// Word-addressed register bank with byte-strobe write port.
// The read port forwards bytes being written in the same cycle.
module ahb_periph_responder_mem
    import ahb_periph_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  logic [3:0]    i_wstrb,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] w_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_word = r_mem[i_ridx];
        if (i_we && (i_widx == i_ridx)) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    w_word[8*b +: 8] = i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = w_word;

endmodule

// File: rtl/ahb_periph_responder.sv
// AHB-Lite slave with programmable wait states and two-cycle ERROR.
// Define AHB_PERIPH_RESP_PROT_CHECK_EN to block user writes to the upper bank half.
module ahb_periph_responder
    import ahb_periph_responder_pkg::*;
#(
    parameter int HADDR       = 32,
    parameter int HDATA       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       periph_htrans,
    input  logic [2:0]       periph_hburst,
    input  logic [2:0]       periph_hsize,
    input  logic [3:0]       periph_hprot,
    input  logic             periph_hmastlock,
    input  logic [HADDR-1:0] periph_haddr,
    input  logic             periph_hwrite,
    input  logic [HDATA-1:0] periph_hwdata,
    output logic [HDATA-1:0] periph_hrdata,
    output logic             periph_hresp,
    output logic             periph_hready
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    if (HDATA != 32) begin : g_bad_hdata
        $error("ahb_periph_responder: HDATA must be 32");
    end
    if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("ahb_periph_responder: DEPTH must be a power of 2, >= 4");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_ws
        $error("ahb_periph_responder: WAIT_STATES must be 0..15");
    end

    resp_state_e   r_state;
    resp_state_e   w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_lanes;
    logic          r_write;
    logic [HDATA-1:0] r_rdata;

    logic          w_ready;
    logic          w_accept;
    logic [AW-1:0] w_aidx;
    logic          w_hi_ok;
    logic          w_size_ok;
    logic          w_align_ok;
    logic          w_prot_ok;
    logic          w_legal;
    logic          w_we;
    logic          w_load;
    logic [AW-1:0] w_ridx;
    logic [HDATA-1:0] w_mem_rdata;
    logic          w_unused;

    assign w_ready  = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign w_accept = w_ready &&
                      ((periph_htrans == HTRANS_NONSEQ) ||
                       (periph_htrans == HTRANS_SEQ));

    assign w_aidx  = periph_haddr[AW+1:2];
    // Bits above the bank must be zero; the bank is never aliased.
    assign w_hi_ok = (periph_haddr[HADDR-1:AW+2] == '0);

    always_comb begin
        w_size_ok  = 1'b1;
        w_align_ok = 1'b1;
        case (periph_hsize)
            HSIZE_BYTE: w_align_ok = 1'b1;
            HSIZE_HALF: w_align_ok = ~periph_haddr[0];
            HSIZE_WORD: w_align_ok = (periph_haddr[1:0] == 2'b00);
            default:    w_size_ok  = 1'b0;
        endcase
    end

`ifdef AHB_PERIPH_RESP_PROT_CHECK_EN
    assign w_prot_ok = ~(periph_hwrite && ~periph_hprot[1] && w_aidx[AW-1]);
`else
    assign w_prot_ok = 1'b1;
`endif

    assign w_legal = w_size_ok && w_align_ok && w_hi_ok && w_prot_ok;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = ST_LAST;
                end
            end
            ST_ERR1: w_next = ST_ERR2;
            default: begin
                w_next = ST_IDLE;
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        w_next     = ST_WAIT;
                        w_cnt_next = WS;
                    end else begin
                        w_next = ST_LAST;
                    end
                end
            end
        endcase
    end

    // Commit happens at the edge that ends the LAST cycle.
    assign w_we   = (r_state == ST_LAST) && r_write;
    assign w_ridx = (r_state == ST_WAIT) ? r_idx : w_aidx;
    assign w_load = (r_state == ST_WAIT) ?
                    ((r_cnt == 4'd1) && !r_write) :
                    (w_accept && w_legal && !periph_hwrite && (WS == 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_lanes <= 4'b0000;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_load ? w_mem_rdata : '0;
            if (w_accept && w_legal) begin
                r_idx   <= w_aidx;
                r_lanes <= byte_lanes(periph_haddr[1:0], periph_hsize);
                r_write <= periph_hwrite;
            end
        end
    end

    ahb_periph_responder_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (HDATA)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wstrb (r_lanes),
        .i_wdata (periph_hwdata),
        .i_ridx  (w_ridx),
        .o_rdata (w_mem_rdata)
    );

    assign periph_hready = w_ready;
    assign periph_hresp  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ?
                           HRESP_ERROR : HRESP_OKAY;
    assign periph_hrdata = r_rdata;

    assign w_unused = ^{periph_hburst, periph_hmastlock, periph_hprot};

endmodule

// File: tb/tb_ahb_periph_responder.sv
// Scoreboard bench: one instance with one wait state, one with none.
// Define AHB_PERIPH_RESP_PROT_CHECK_EN to exercise the protection check.
module tb_ahb_periph_responder;

    typedef struct {
        string       tag;
        logic        rd;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic [1:0]  htrans    [2];
    logic [2:0]  hburst    [2];
    logic [2:0]  hsize     [2];
    logic [3:0]  hprot     [2];
    logic        hmastlock [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hresp     [2];
    logic        hready    [2];

    int          n_chk  = 0;
    int          n_pass = 0;
    exp_t        sb [$];
    logic [31:0] model [2][64];
    logic        pend  [2];
    int          waits [2];
    bit          mon_en = 1'b0;

    ahb_periph_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk              (clk),
        .reset            (rst[0]),
        .periph_htrans    (htrans[0]),
        .periph_hburst    (hburst[0]),
        .periph_hsize     (hsize[0]),
        .periph_hprot     (hprot[0]),
        .periph_hmastlock (hmastlock[0]),
        .periph_haddr     (haddr[0]),
        .periph_hwrite    (hwrite[0]),
        .periph_hwdata    (hwdata[0]),
        .periph_hrdata    (hrdata[0]),
        .periph_hresp     (hresp[0]),
        .periph_hready    (hready[0])
    );

    ahb_periph_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk              (clk),
        .reset            (rst[1]),
        .periph_htrans    (htrans[1]),
        .periph_hburst    (hburst[1]),
        .periph_hsize     (hsize[1]),
        .periph_hprot     (hprot[1]),
        .periph_hmastlock (hmastlock[1]),
        .periph_haddr     (haddr[1]),
        .periph_hwrite    (hwrite[1]),
        .periph_hwdata    (hwdata[1]),
        .periph_hrdata    (hrdata[1]),
        .periph_hresp     (hresp[1]),
        .periph_hready    (hready[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] a,
                                              input logic [2:0] sz);
        case (sz)
            3'd0:    return 32'h0000_00FF << (8 * a[1:0]);
            3'd1:    return 32'h0000_FFFF << (8 * a[1:0]);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Completion monitor: pops one expectation per finished data phase.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] exp_rd;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    pend[d]  = 1'b0;
                    waits[d] = 0;
                    sb.delete();
                end else begin
                    exp_rd = 32'h0;
                    if (pend[d]) begin
                        if (sb.size() == 0) begin
                            chk("sb_empty", 32'(pend[d]), 32'h0);
                            pend[d] = 1'b0;
                        end else begin
                            e = sb[0];
                            if (!hready[d]) begin
                                chk({e.tag, "_wait_resp"}, 32'(hresp[d]),
                                    32'(e.err));
                                waits[d]++;
                            end else begin
                                chk({e.tag, "_resp"}, 32'(hresp[d]),
                                    32'(e.err));
                                chk({e.tag, "_waits"}, waits[d],
                                    e.err ? 1 : ws_of(d));
                                if (e.rd && !e.err) exp_rd = e.rdata;
                                void'(sb.pop_front());
                                waits[d] = 0;
                            end
                        end
                    end
                    chk("hrdata", hrdata[d], exp_rd);
                    if (hready[d]) pend[d] = htrans[d][1];
                end
            end
        end
    end

    task automatic addr_phase(input int d, input string tag,
                              input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd,
                              input logic [3:0] prot, input logic err);
        exp_t        e;
        logic [31:0] m;
        htrans[d] = 2'd2;
        hwrite[d] = wr;
        haddr[d]  = a;
        hsize[d]  = sz;
        hprot[d]  = prot;
        e.tag   = tag;
        e.rd    = !wr;
        e.err   = err;
        e.rdata = model[d][a[7:2]];
        if (wr && !err) begin
            m = lane_mask(a, sz);
            model[d][a[7:2]] = (model[d][a[7:2]] & ~m) | (wd & m);
        end
        sb.push_back(e);
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hready[d] && n < 20);
        if (!hready[d]) chk("xfer_timeout", 32'(hready[d]), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int d, input string tag, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] prot,
                        input logic err);
        addr_phase(d, tag, wr, a, sz, wd, prot, err);
        @(posedge clk); #1;
        htrans[d] = 2'd0;
        hwdata[d] = wd;
        wait_done(d);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          d;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;  htrans[i] = 2'd0; hburst[i] = 3'd0;
            hsize[i] = 3'd2; hprot[i] = 4'b0011; hmastlock[i] = 1'b0;
            haddr[i] = '0;  hwrite[i] = 1'b0; hwdata[i] = '0;
            pend[i] = 1'b0; waits[i] = 0;
            for (int j = 0; j < 64; j++) model[i][j] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_hready", 32'(hready[i]), 32'h1);
            chk("rst_hresp",  32'(hresp[i]),  32'h0);
            chk("rst_hrdata", hrdata[i], 32'h0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        mon_en = 1'b1;

        xfer(0, "rd_reset", 0, 32'h8, 3'd2, 0, 4'h3, 0);
        xfer(0, "wr_word", 1, 32'h4, 3'd2, 32'hDEAD_BEEF, 4'h3, 0);
        xfer(0, "wr_byte", 1, 32'h6, 3'd0, 32'h005A_0000, 4'h3, 0);
        xfer(0, "rd_merge", 0, 32'h4, 3'd2, 0, 4'h3, 0);
        xfer(0, "wr_half", 1, 32'hA, 3'd1, 32'h7777_0000, 4'h3, 0);
        xfer(0, "rd_half", 0, 32'h8, 3'd0, 0, 4'h3, 0);

        addr_phase(1, "b2b_wr", 1, 32'h10, 3'd2, 32'h1234_5678, 4'h3, 0);
        @(posedge clk); #1;
        hwdata[1] = 32'h1234_5678;
        addr_phase(1, "b2b_rd", 0, 32'h10, 3'd2, 0, 4'h3, 0);
        @(posedge clk); #1;
        htrans[1] = 2'd0;
        wait_done(1);

        xfer(0, "err_oor", 0, 32'h100, 3'd2, 0, 4'h3, 1);
        xfer(0, "err_mis", 1, 32'h3, 3'd1, 32'hAAAA_AAAA, 4'h3, 1);
        xfer(0, "err_size", 1, 32'h0, 3'd3, 32'h5555_5555, 4'h3, 1);
        xfer(0, "err_alias", 1, 32'h1000_0000, 3'd2, 32'h0BAD_0BAD, 4'h3, 1);
        xfer(0, "rd_after_err", 0, 32'h0, 3'd2, 0, 4'h3, 0);
        xfer(0, "rd_after_err4", 0, 32'h4, 3'd2, 0, 4'h3, 0);

        addr_phase(1, "err_ws0", 1, 32'h104, 3'd2, 32'hFFFF_0000, 4'h3, 1);
        @(posedge clk); #1;
        htrans[1] = 2'd0;
        @(posedge clk); #1;
        addr_phase(1, "rd_in_err2", 0, 32'h10, 3'd2, 0, 4'h3, 0);
        @(posedge clk); #1;
        htrans[1] = 2'd0;
        wait_done(1);

        addr_phase(0, "rst_wr", 1, 32'h20, 3'd2, 32'hFFFF_FFFF, 4'h3, 0);
        @(posedge clk); #1;
        htrans[0] = 2'd0;
        hwdata[0] = 32'hFFFF_FFFF;
        rst[0]    = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_hready", 32'(hready[0]), 32'h1);
        chk("rst_mid_hresp",  32'(hresp[0]),  32'h0);
        for (int j = 0; j < 64; j++) model[0][j] = '0;
        @(posedge clk); #1;
        xfer(0, "rd_after_rst", 0, 32'h20, 3'd2, 0, 4'h3, 0);

`ifdef AHB_PERIPH_RESP_PROT_CHECK_EN
        xfer(0, "prot_user", 1, 32'hA0, 3'd2, 32'hCAFE_0001, 4'b0001, 1);
`else
        xfer(0, "prot_user", 1, 32'hA0, 3'd2, 32'hCAFE_0001, 4'b0001, 0);
`endif
        xfer(0, "prot_rd1", 0, 32'hA0, 3'd2, 0, 4'b0001, 0);
        xfer(0, "prot_priv", 1, 32'hA0, 3'd2, 32'hCAFE_0002, 4'b0011, 0);
        xfer(0, "prot_rd2", 0, 32'hA0, 3'd2, 0, 4'b0001, 0);
        xfer(0, "prot_lo", 1, 32'h40, 3'd2, 32'h0000_1111, 4'b0001, 0);
        xfer(0, "prot_lo_rd", 0, 32'h40, 3'd2, 0, 4'b0001, 0);

        for (int i = 0; i < 48; i++) begin
            d  = i % 2;
            sz = 3'($urandom_range(0, 2));
            a  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 3'd1) a[1]   = 1'($urandom_range(0, 1));
            xfer(d, "rnd", 1'($urandom_range(0, 1)), a, sz, $urandom,
                 4'b0011, 0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
